dff_scoreboard: RTL

Self-checking monitor for the gate-level D flip-flop benches: samples the DUT's D, Q and Qb on the bench clock, predicts Q with a behavioural golden register, and counts checks and mismatches. It sits beside the DUT in the random-stimulus testbench, which is the observing and judging end of the stimulus path. It replaces eyeballing the per-nanosecond display dump with a pass/fail flag and counters.

---
 rtl/dff_sb_pkg.sv | 18 +
 rtl/dff_sb_satcnt.sv | 19 +
 rtl/dff_scoreboard.sv | 123 ++++++++++++
 3 files changed

// File: rtl/dff_sb_pkg.sv
// Shared types and default parameters for the D flip-flop scoreboard.
package dff_sb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WARM  = 2'd1,
        ST_CHECK = 2'd2,
        ST_FAIL  = 2'd3
    } sb_state_t;

    localparam int DEF_CNT_W     = 16;
    localparam int DEF_WARMUP    = 2;
    localparam int DEF_ERR_LIMIT = 1;

    // Wide enough for the largest warm-up length (255).
    localparam int WARM_W = 8;

endpackage

// File: rtl/dff_sb_satcnt.sv
// Saturating up-counter: sync clear has priority, then increment until all-ones.
module dff_sb_satcnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/dff_scoreboard.sv
// Scoreboard for the gate-level D flip-flop benches: golden register, FSM, compare.
// Optional build macro DFF_SB_QB_CHECK_EN adds the Qb == ~Q complement check.
//
// state | meaning
// IDLE  | checking disabled, counters hold
// WARM  | enabled, settling before comparisons start
// CHECK | comparing Q against the golden register every edge
// FAIL  | error limit reached, frozen until Rst
module dff_scoreboard
    import dff_sb_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int WARMUP    = DEF_WARMUP,
    parameter int ERR_LIMIT = DEF_ERR_LIMIT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             en,
    input  logic             dut_d,
    input  logic             dut_q,
    input  logic             dut_qb,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             mismatch,
    output logic             fail,
    output logic             active
);

    sb_state_t         state, state_nx;
    logic [WARM_W-1:0] warm_cnt, warm_nx;
    logic              exp_q;
    logic              bad;
    logic              do_chk;
    logic              hit_limit;

`ifdef DFF_SB_QB_CHECK_EN
    always_comb begin
        // Q and Qb faults on the same edge still count as one mismatch.
        bad = (dut_q !== exp_q) || (dut_qb !== ~dut_q);
    end
`else
    logic unused_qb;
    assign unused_qb = dut_qb;

    always_comb begin
        bad = (dut_q !== exp_q);
    end
`endif

    assign do_chk    = (state == ST_CHECK);
    assign hit_limit = do_chk && bad && (err_cnt == CNT_W'(ERR_LIMIT - 1));

    always_comb begin
        state_nx = state;
        warm_nx  = warm_cnt;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    warm_nx  = '0;
                    // The enabling edge is the first warm-up edge.
                    state_nx = (WARMUP <= 1) ? ST_CHECK : ST_WARM;
                end
            end
            ST_WARM: begin
                if (!en) begin
                    state_nx = ST_IDLE;
                end else begin
                    warm_nx = warm_cnt + WARM_W'(1);
                    if (warm_nx == WARM_W'(WARMUP - 1)) begin
                        state_nx = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (hit_limit) begin
                    state_nx = ST_FAIL;
                end else if (!en) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_FAIL: begin
                state_nx = ST_FAIL;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= ST_IDLE;
            warm_cnt <= '0;
            exp_q    <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            state    <= state_nx;
            warm_cnt <= warm_nx;
            mismatch <= do_chk && bad;
            if (en) begin
                exp_q <= dut_d;
            end
        end
    end

    assign fail   = (state == ST_FAIL);
    assign active = (state == ST_CHECK);

    dff_sb_satcnt #(.W(CNT_W)) u_chk_cnt (
        .clk (Clk),
        .clr (Rst),
        .inc (do_chk),
        .q   (chk_cnt)
    );

    dff_sb_satcnt #(.W(CNT_W)) u_err_cnt (
        .clk (Clk),
        .clr (Rst),
        .inc (do_chk && bad),
        .q   (err_cnt)
    );

endmodule
